// File: rtl/delay_chain_meas_ctrl.sv
// Launches edges into the inverter delay chain and timestamps their return,
// accumulating min/max/sum over 2**SAMPLES_LOG2 launches per run.
//
// state  | meaning
// IDLE   | waiting for start, results held
// SETTLE | return must sit at the idle level for SETTLE_CYC cycles
// LAUNCH | toggle chain_launch, clear the delay counter
// WAIT   | count cycles until the synchronized return matches the launch
// RECORD | fold the captured delay into min/max/sum/sample_cnt
// DONE   | one-cycle done pulse, then back to IDLE
module delay_chain_meas_ctrl #(
    parameter int CNT_W        = 16,
    parameter int SAMPLES_LOG2 = 3,
    parameter int TIMEOUT      = 1000,
    parameter int SETTLE_CYC   = 4,
    parameter bit INVERT       = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          chain_return,
    output logic                          chain_launch,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err,
    output logic [CNT_W-1:0]              delay_min,
    output logic [CNT_W-1:0]              delay_max,
    output logic [CNT_W+SAMPLES_LOG2-1:0] delay_sum,
    output logic [SAMPLES_LOG2:0]         sample_cnt
);

    localparam int NUM_SAMPLES = 2 ** SAMPLES_LOG2;
    localparam int STAB_W      = $clog2(SETTLE_CYC + 1);

    localparam logic [CNT_W-1:0]      TMR_LOAD    = CNT_W'(TIMEOUT - 1);
    localparam logic [STAB_W-1:0]     STAB_LAST   = STAB_W'(SETTLE_CYC - 1);
    localparam logic [SAMPLES_LOG2:0] LAST_SAMPLE = (SAMPLES_LOG2 + 1)'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        RECORD = 3'd4,
        DONE   = 3'd5
    } stateType;

    stateType          state;
    stateType          stateNext;
    logic              syncMeta;
    logic              syncOut;
    logic              retOk;
    logic [CNT_W-1:0]  phaseTmr;
    logic [STAB_W-1:0] stabCnt;
    logic [CNT_W-1:0]  delayCnt;
    logic [CNT_W-1:0]  delayCap;
    logic              startAccept;
    logic              timeoutHit;

    assign retOk = (syncOut == (chain_launch ^ INVERT));
    assign busy  = (state == SETTLE) || (state == LAUNCH) || (state == WAIT) || (state == RECORD);
    assign done  = (state == DONE);

    always_comb begin
        stateNext   = state;
        startAccept = 1'b0;
        timeoutHit  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    stateNext   = SETTLE;
                    startAccept = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (retOk && (stabCnt == STAB_LAST)) begin
                    stateNext = LAUNCH;
                end else if (phaseTmr == '0) begin
                    stateNext  = DONE;
                    timeoutHit = 1'b1;
                end
            end
            LAUNCH: begin
                stateNext = abort ? IDLE : WAIT;
            end
            WAIT: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (retOk) begin
                    stateNext = RECORD;
                end else if (phaseTmr == '0) begin
                    stateNext  = DONE;
                    timeoutHit = 1'b1;
                end
            end
            RECORD: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (sample_cnt == LAST_SAMPLE) begin
                    stateNext = DONE;
                end else begin
                    stateNext = SETTLE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            syncMeta     <= 1'b0;
            syncOut      <= 1'b0;
            phaseTmr     <= '0;
            stabCnt      <= '0;
            delayCnt     <= '0;
            delayCap     <= '0;
            chain_launch <= 1'b0;
            timeout_err  <= 1'b0;
            delay_min    <= '1;
            delay_max    <= '0;
            delay_sum    <= '0;
            sample_cnt   <= '0;
        end else begin
            syncMeta <= chain_return;
            syncOut  <= syncMeta;
            state    <= stateNext;

            // One down-counter times whichever phase is active; reloaded on every state change.
            if (stateNext != state) begin
                phaseTmr <= TMR_LOAD;
                stabCnt  <= '0;
            end else begin
                if (phaseTmr != '0) begin
                    phaseTmr <= phaseTmr - 1'b1;
                end
                if (state == SETTLE) begin
                    stabCnt <= retOk ? stabCnt + 1'b1 : '0;
                end
            end

            if (state == LAUNCH || startAccept) begin
                delayCnt <= '0;
            end else if (state == WAIT) begin
                delayCnt <= delayCnt + 1'b1;
            end
            if (state == WAIT && retOk) begin
                delayCap <= delayCnt;
            end

            if (stateNext == IDLE || stateNext == DONE) begin
                chain_launch <= 1'b0;
            end else if (state == LAUNCH) begin
                chain_launch <= ~chain_launch;
            end

            if (startAccept) begin
                timeout_err <= 1'b0;
                delay_min   <= '1;
                delay_max   <= '0;
                delay_sum   <= '0;
                sample_cnt  <= '0;
            end
            if (timeoutHit) begin
                timeout_err <= 1'b1;
            end

            // An abort landing on RECORD discards the sample in flight.
            if (state == RECORD && !abort) begin
                if (delayCap < delay_min) begin
                    delay_min <= delayCap;
                end
                if (delayCap > delay_max) begin
                    delay_max <= delayCap;
                end
                delay_sum  <= delay_sum + {{SAMPLES_LOG2{1'b0}}, delayCap};
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_chain_meas_ctrl.sv
// Bench for delay_chain_meas_ctrl: loopback, registered 5/9-cycle chain,
// stuck return, settle failure, abort and mid-run reset scenarios.
module tb_delay_chain_meas_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        chain_return;
    logic        chain_launch;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] delay_min;
    logic [15:0] delay_max;
    logic [18:0] delay_sum;
    logic [3:0]  sample_cnt;

    typedef struct packed {
        logic [15:0] mn;
        logic [15:0] mx;
        logic [18:0] sum;
        logic [3:0]  cnt;
        logic        terr;
    } resT;

    resT  sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  chainMode = 2'd0;
    logic        forceVal  = 1'b0;
    logic [15:0] pipe      = '0;

    delay_chain_meas_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .chain_return (chain_return),
        .chain_launch (chain_launch),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err),
        .delay_min    (delay_min),
        .delay_max    (delay_max),
        .delay_sum    (delay_sum),
        .sample_cnt   (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered chain: rising edges take 5 cycles, falling edges take 9.
    always @(posedge clk) pipe <= {pipe[14:0], chain_launch};

    assign chain_return = (chainMode == 2'd0) ? chain_launch :
                          (chainMode == 2'd1) ? (chain_launch ? pipe[4] : pipe[8]) :
                          forceVal;

    function automatic resT modelRun(input int dRise, input int dFall, input int n, input bit terr);
        resT r;
        int  d;
        r.mn   = 16'hFFFF;
        r.mx   = '0;
        r.sum  = '0;
        r.cnt  = 4'(n);
        r.terr = terr;
        for (int i = 0; i < n; i++) begin
            d = ((i % 2) == 0 ? dRise : dFall) + 2;
            if (d < int'(r.mn)) r.mn = 16'(d);
            if (d > int'(r.mx)) r.mx = 16'(d);
            r.sum = r.sum + 19'(d);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int cycles, output bit seen,
                            output bit busyBefore, output bit launchHi);
        cycles     = 0;
        seen       = 1'b0;
        busyBefore = busy;
        launchHi   = 1'b0;
        while (!seen && cycles < limit) begin
            busyBefore = busy;
            tick();
            cycles++;
            if (chain_launch) launchHi = 1'b1;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        resT e;
        resT g;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        sb.push_back(modelRun(0, 0, 0, 1'b0));
        checks++;
        if (chain_launch !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got launch=%b busy=%b, expected 0 0", chain_launch, busy);
        end
        checks++;
        if (done !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got done=%b terr=%b, expected 0 0", done, timeout_err);
        end
        g = {delay_min, delay_max, delay_sum, sample_cnt, timeout_err};
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_results: got min=%h max=%h sum=%h cnt=%h, expected min=%h max=%h sum=%h cnt=%h",
                     g.mn, g.mx, g.sum, g.cnt, e.mn, e.mx, e.sum, e.cnt);
        end
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_loopback();
        resT e;
        resT g;
        int  cyc;
        bit  seen, busyBefore, launchHi;
        chainMode = 2'd0;
        tick();
        sb.push_back(modelRun(0, 0, 8, 1'b0));
        pulseStart();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL loop_busy_rise: got busy=%b, expected 1", busy);
        end
        waitDone(500, cyc, seen, busyBefore, launchHi);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL loop_done_seen: got no done within %0d cycles, expected done", cyc);
        end
        checks++;
        if (busy !== 1'b0 || busyBefore !== 1'b1) begin
            errors++;
            $display("FAIL loop_busy_fall: got busy=%b prevBusy=%b, expected 0 1", busy, busyBefore);
        end
        g = {delay_min, delay_max, delay_sum, sample_cnt, timeout_err};
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL loop_results: got min=%0d max=%0d sum=%0d cnt=%0d terr=%b, expected min=%0d max=%0d sum=%0d cnt=%0d terr=%b",
                     g.mn, g.mx, g.sum, g.cnt, g.terr, e.mn, e.mx, e.sum, e.cnt, e.terr);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL loop_done_width: got done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_chain_model();
        resT e;
        resT g;
        int  cyc;
        bit  seen, busyBefore, launchHi;
        chainMode = 2'd1;
        repeat (12) tick();
        sb.push_back(modelRun(5, 9, 8, 1'b0));
        pulseStart();
        waitDone(1000, cyc, seen, busyBefore, launchHi);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL chain_done_seen: got no done within %0d cycles, expected done", cyc);
        end
        g = {delay_min, delay_max, delay_sum, sample_cnt, timeout_err};
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL chain_results: got min=%0d max=%0d sum=%0d cnt=%0d terr=%b, expected min=%0d max=%0d sum=%0d cnt=%0d terr=%b",
                     g.mn, g.mx, g.sum, g.cnt, g.terr, e.mn, e.mx, e.sum, e.cnt, e.terr);
        end
    endtask

    task automatic test_stuck_low();
        resT e;
        resT g;
        int  cyc;
        bit  seen, busyBefore, launchHi;
        chainMode = 2'd2;
        forceVal  = 1'b0;
        repeat (4) tick();
        sb.push_back(modelRun(0, 0, 0, 1'b1));
        pulseStart();
        waitDone(3000, cyc, seen, busyBefore, launchHi);
        checks++;
        if (!seen || chain_launch !== 1'b0 || busy !== 1'b0 || !launchHi) begin
            errors++;
            $display("FAIL stuck_done: got seen=%b launch=%b busy=%b launched=%b, expected 1 0 0 1",
                     seen, chain_launch, busy, launchHi);
        end
        g = {delay_min, delay_max, delay_sum, sample_cnt, timeout_err};
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL stuck_results: got min=%h cnt=%0d terr=%b, expected min=%h cnt=%0d terr=%b",
                     g.mn, g.cnt, g.terr, e.mn, e.cnt, e.terr);
        end
        tick();
        pulseStart();
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stuck_restart_clear: got terr=%b busy=%b, expected 0 1", timeout_err, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL stuck_abort: got busy=%b done=%b terr=%b, expected 0 0 0", busy, done, timeout_err);
        end
    endtask

    task automatic test_settle_fail();
        resT e;
        resT g;
        int  cyc;
        bit  seen, busyBefore, launchHi;
        chainMode = 2'd2;
        forceVal  = 1'b1;
        repeat (4) tick();
        sb.push_back(modelRun(0, 0, 0, 1'b1));
        pulseStart();
        waitDone(1500, cyc, seen, busyBefore, launchHi);
        checks++;
        if (!seen || cyc != 1000) begin
            errors++;
            $display("FAIL settle_timeout_len: got seen=%b after %0d cycles, expected done after 1000", seen, cyc);
        end
        checks++;
        if (launchHi || chain_launch !== 1'b0) begin
            errors++;
            $display("FAIL settle_no_launch: got launched=%b launch=%b, expected 0 0", launchHi, chain_launch);
        end
        g = {delay_min, delay_max, delay_sum, sample_cnt, timeout_err};
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL settle_results: got min=%h cnt=%0d terr=%b, expected min=%h cnt=%0d terr=%b",
                     g.mn, g.cnt, g.terr, e.mn, e.cnt, e.terr);
        end
        forceVal = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_abort();
        resT e;
        resT g;
        int  n;
        int  doneCount;
        chainMode = 2'd1;
        repeat (12) tick();
        sb.push_back(modelRun(5, 9, 2, 1'b0));
        pulseStart();
        n = 0;
        while (sample_cnt !== 4'd2 && n < 300) begin tick(); n++; end
        pulseStart();
        checks++;
        if (sample_cnt !== 4'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_start_ignored: got cnt=%0d busy=%b, expected 2 1", sample_cnt, busy);
        end
        n = 0;
        while (chain_launch !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (chain_launch !== 1'b1) begin
            errors++;
            $display("FAIL abort_reach_wait: got launch=%b, expected 1", chain_launch);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || chain_launch !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: got busy=%b done=%b launch=%b, expected 0 0 0", busy, done, chain_launch);
        end
        g = {delay_min, delay_max, delay_sum, sample_cnt, timeout_err};
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL abort_results: got min=%0d max=%0d sum=%0d cnt=%0d terr=%b, expected min=%0d max=%0d sum=%0d cnt=%0d terr=%b",
                     g.mn, g.mx, g.sum, g.cnt, g.terr, e.mn, e.mx, e.sum, e.cnt, e.terr);
        end
        doneCount = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) doneCount++;
        end
        checks++;
        if (doneCount != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, expected 0", doneCount);
        end
    endtask

    task automatic test_start_abort_same();
        resT e;
        resT g;
        sb.push_back(modelRun(5, 9, 2, 1'b0));
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_same: got busy=%b, expected 0", busy);
        end
        g = {delay_min, delay_max, delay_sum, sample_cnt, timeout_err};
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL start_abort_results: got min=%0d cnt=%0d, expected min=%0d cnt=%0d",
                     g.mn, g.cnt, e.mn, e.cnt);
        end
    endtask

    task automatic test_reset_midrun();
        resT e;
        resT g;
        int  n;
        chainMode = 2'd1;
        repeat (12) tick();
        sb.push_back(modelRun(0, 0, 0, 1'b0));
        pulseStart();
        n = 0;
        while (sample_cnt !== 4'd1 && n < 200) begin tick(); n++; end
        n = 0;
        while (chain_launch !== 1'b0 && n < 100) begin tick(); n++; end
        checks++;
        if (busy !== 1'b1 || sample_cnt !== 4'd1 || delay_min !== 16'd7) begin
            errors++;
            $display("FAIL midrun_setup: got busy=%b cnt=%0d min=%0d, expected 1 1 7", busy, sample_cnt, delay_min);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || chain_launch !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_ctrl: got busy=%b done=%b launch=%b, expected 0 0 0", busy, done, chain_launch);
        end
        g = {delay_min, delay_max, delay_sum, sample_cnt, timeout_err};
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL midrun_reset_results: got min=%h max=%h sum=%h cnt=%h, expected min=%h max=%h sum=%h cnt=%h",
                     g.mn, g.mx, g.sum, g.cnt, e.mn, e.mx, e.sum, e.cnt);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        test_reset();
        test_loopback();
        test_chain_model();
        test_stuck_low();
        test_settle_fail();
        test_abort();
        test_start_abort_same();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running at 500us, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/delay_chain_meas_ctrl.md
Name: delay_chain_meas_ctrl

Overview:
- Sequences propagation-delay measurements on the inverter delay chain between two GPIO pads.
- Drives edges into the chain input pad and timestamps their arrival at the chain output pad with a clock-cycle counter.
- Repeats for NUM_SAMPLES launches and reports min/max/sum for readout by the QT test software.
- Sits in MODULE_top between the chain pads and the register/readout logic.

Parameters:
- CNT_W, 16, width of the per-launch delay counter and the min/max outputs.
- SAMPLES_LOG2, 3, log2 of launches per run (NUM_SAMPLES = 2**SAMPLES_LOG2).
- TIMEOUT, 1000, cycles allowed per settle or propagate phase; must be < 2**CNT_W.
- SETTLE_CYC, 4, cycles the return must be stable at the expected idle level before each launch.
- INVERT, 0, chain polarity: expected return level = chain_launch XOR INVERT (0 for an even stage count).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- abort  in  1  one-cycle pulse; cancels a run in progress.
- chain_return  in  1  asynchronous chain output pad.
- chain_launch  out  1  registered chain input pad.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a run (success or timeout).
- timeout_err  out  1  sticky per run; set on timeout, cleared by the next accepted start.
- delay_min  out  CNT_W  minimum measured delay.
- delay_max  out  CNT_W  maximum measured delay.
- delay_sum  out  CNT_W+SAMPLES_LOG2  sum of measured delays.
- sample_cnt  out  SAMPLES_LOG2+1  completed samples in the current or last run.

Behaviour:
- Reset, in all states:
  - chain_launch=0, busy=0, done=0, timeout_err=0.
  - delay_min=all-ones, delay_max=0, delay_sum=0, sample_cnt=0.
  - Synchronizer flops=0; state=IDLE.
- chain_return passes through a 2-flop synchronizer (sync2 = its output). Comparisons use ret_ok = (sync2 == chain_launch ^ INVERT).
- State IDLE:
  - start=1 moves to SETTLE next cycle.
  - On that move: busy=1, timeout_err=0, sample_cnt=0, delay_min=all-ones, delay_max=0, delay_sum=0, counters=0.
  - start while busy is ignored.
- State SETTLE:
  - Stability counter increments while ret_ok=1 and resets to 0 while ret_ok=0.
  - When it reaches SETTLE_CYC, go to LAUNCH.
  - Phase counter reaching TIMEOUT first triggers a timeout.
- State LAUNCH: one cycle. Toggle chain_launch, clear the delay counter to 0, go to WAIT.
- State WAIT:
  - Delay counter increments every cycle.
  - On the first cycle ret_ok=1, capture d = counter value including the current cycle, then go to RECORD.
  - Measured value: a zero-delay loopback gives d=2 (synchronizer latency); a registered D-cycle chain model gives d=D+2.
  - Counter reaching TIMEOUT without a match triggers a timeout.
- State RECORD: one cycle.
  - Update delay_min=min(delay_min,d), delay_max=max(delay_max,d), delay_sum+=d, sample_cnt+=1.
  - If sample_cnt reaches NUM_SAMPLES go to DONE, else go to SETTLE.
  - Alternate launches therefore measure rising and falling edges.
- State DONE: done=1 for exactly one cycle, busy=0, chain_launch=0, go to IDLE.
  - Results hold until the next accepted start.
- Timeout (SETTLE or WAIT):
  - timeout_err=1, then DONE path: done pulse, busy=0, chain_launch=0.
  - Partial results and sample_cnt are retained.
- abort in any busy state:
  - Next state IDLE with chain_launch=0, busy=0, no done pulse.
  - Results retained; timeout_err unchanged.
  - abort overrides a simultaneous match or timeout.
- Simultaneous start and abort in IDLE: abort wins, the run does not start.
- rst mid-run: immediate return to reset values on the next edge.
- Arithmetic is unsigned. delay_sum cannot overflow because its width is CNT_W+SAMPLES_LOG2.

Test Plan:
- Zero-delay loopback (chain_return=chain_launch), defaults, start pulse: 8 samples, delay_min=delay_max=2, delay_sum=16, sample_cnt=8. done pulses once; busy falls the same cycle done rises; timeout_err=0.
- Registered chain model, delay alternating 5/9 cycles: delay_min=7, delay_max=11, delay_sum=72, sample_cnt=8.
- chain_return stuck at 0, INVERT=0: first launch (rising) times out. timeout_err=1, sample_cnt=0, done pulses, chain_launch=0. A following start clears timeout_err.
- chain_return forced to 1 before start (settle fails): timeout after 1000 SETTLE cycles, chain_launch never toggles, timeout_err=1.
- abort pulse during WAIT of sample 3: busy=0 the next cycle, no done pulse, sample_cnt=2, chain_launch=0. start during busy is ignored (sample_cnt unaffected).
- rst asserted mid-WAIT: all outputs return to reset values on the next edge, including delay_min=0xFFFF.
